// File: rtl/cordic_pkg.sv
// cordic_pkg: angle constants, default CORDIC latency and the in-flight tag type
// shared by the CORDIC scheduler.
package cordic_pkg;

    localparam logic [31:0] DEG_0   = 32'h0000_0000;
    localparam logic [31:0] DEG_45  = 32'h2000_0000;
    localparam logic [31:0] DEG_90  = 32'h4000_0000;
    localparam logic [31:0] DEG_180 = 32'h8000_0000;

    localparam int CORDIC_LATENCY = 9;

    // id is wide enough for the largest supported requester count (8)
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter; picks the first set request
// at or after ptr (wrapping) and returns it one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W:0] s;

    // scan from the farthest offset down so the closest valid requester wins
    always_comb begin
        idx = '0;
        s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (ID_W+1)'(i);
            s = s >= (ID_W+1)'(NUM_REQ) ? s - (ID_W+1)'(NUM_REQ) : s;
            if (req[s[ID_W-1:0]]) idx = s[ID_W-1:0];
        end
        grant = |req ? NUM_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one pipelined CORDIC between requesters.
// Optional per-requester grant counters when CORDIC_SCHED_STATS_EN is defined.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ANGLE_WIDTH = 32,
    parameter int WIDTH       = 16,
    parameter int LATENCY     = CORDIC_LATENCY,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0]   req_angle,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [ANGLE_WIDTH-1:0]           cordic_angle,
    input  logic signed [WIDTH:0]            cordic_x,
    input  logic signed [WIDTH:0]            cordic_y,
    output logic                             rsp_valid,
    output logic [ID_W-1:0]                  rsp_id,
    output logic signed [WIDTH:0]            rsp_x,
    output logic signed [WIDTH:0]            rsp_y,
    output logic [$clog2(LATENCY+2)-1:0]     inflight
`ifdef CORDIC_SCHED_STATS_EN
    ,
    input  logic                             stats_clr,
    output logic [NUM_REQ*16-1:0]            grant_cnt
`endif
);

    localparam int IW = $clog2(LATENCY + 2);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] g_idx;
    logic            gnt;
    logic            done;
    // stage 0 lines up with cordic_angle; stages 1..LATENCY track the CORDIC pipe
    tag_t            tags [0:LATENCY];

    assign gnt  = |req_valid;
    assign done = tags[LATENCY].valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (req_ready),
        .idx   (g_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cordic_angle <= '0;
            rr_ptr       <= '0;
            for (int i = 0; i <= LATENCY; i++) tags[i] <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_x        <= '0;
            rsp_y        <= '0;
            inflight     <= '0;
        end else begin
            if (gnt) begin
                cordic_angle <= req_angle[g_idx*ANGLE_WIDTH +: ANGLE_WIDTH];
                rr_ptr       <= g_idx == ID_W'(NUM_REQ - 1) ? '0 : g_idx + 1'b1;
            end
            tags[0] <= '{valid: gnt, id: 3'(g_idx)};
            for (int i = 1; i <= LATENCY; i++) tags[i] <= tags[i-1];
            rsp_valid <= done;
            if (done) begin
                rsp_id <= ID_W'(tags[LATENCY].id);
                rsp_x  <= cordic_x;
                rsp_y  <= cordic_y;
            end
            // an operation stops counting the moment its response is presented
            inflight <= inflight + IW'(gnt) - IW'(done);
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (stats_clr) begin
            grant_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++)
                if (req_ready[k] && grant_cnt[k*16 +: 16] != 16'hFFFF)
                    grant_cnt[k*16 +: 16] <= grant_cnt[k*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: randomized scoreboard bench for cordic_sched with a behavioural
// CORDIC stand-in; exercises grant counters when CORDIC_SCHED_STATS_EN is defined.
module tb_cordic_sched;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int W  = 16;
    localparam int L  = 9;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N-1:0]          req_valid = '0;
    logic [N*AW-1:0]       req_angle = '0;
    logic [N-1:0]          req_ready;
    logic [AW-1:0]         cordic_angle;
    logic signed [W:0]     cordic_x;
    logic signed [W:0]     cordic_y;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic signed [W:0]     rsp_x;
    logic signed [W:0]     rsp_y;
    logic [3:0]            inflight;
`ifdef CORDIC_SCHED_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [N*16-1:0]       grant_cnt;
    int                    cnt [N];
`endif

    cordic_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_angle    (req_angle),
        .req_ready    (req_ready),
        .cordic_angle (cordic_angle),
        .cordic_x     (cordic_x),
        .cordic_y     (cordic_y),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_x        (rsp_x),
        .rsp_y        (rsp_y),
        .inflight     (inflight)
`ifdef CORDIC_SCHED_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // behavioural CORDIC: ideal cos/sin scaled to 30000, delayed L edges
    function automatic logic signed [W:0] cx(input logic [AW-1:0] a);
        real r;
        r = 2.0 * 3.14159265358979 * real'(a) / 4294967296.0;
        return 17'($rtoi($cos(r) * 30000.0));
    endfunction

    function automatic logic signed [W:0] cy(input logic [AW-1:0] a);
        real r;
        r = 2.0 * 3.14159265358979 * real'(a) / 4294967296.0;
        return 17'($rtoi($sin(r) * 30000.0));
    endfunction

    logic signed [W:0] px [L];
    logic signed [W:0] py [L];
    always @(posedge clk) begin
        px[0] <= cx(cordic_angle);
        py[0] <= cy(cordic_angle);
        for (int i = 1; i < L; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign cordic_x = px[L-1];
    assign cordic_y = py[L-1];

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int                id;
        logic signed [W:0] x;
        logic signed [W:0] y;
        int                due;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            mptr = 0;
    int            maxinf = 0;
    int            w;
    logic [AW-1:0] a;

    // scoreboard: pop/compare responses, then model arbitration for the coming edge
    always @(negedge clk) begin
        #1;
        if (rst) begin
            q.delete();
            mptr = 0;
`ifdef CORDIC_SCHED_STATS_EN
            for (int k = 0; k < N; k++) cnt[k] = 0;
`endif
        end else begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_x", rsp_x, e.x);
                    chk("rsp_y", rsp_y, e.y);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rsp_missing", 0, 1);
                void'(q.pop_front());
            end
            chk("inflight", inflight, q.size());
            if (int'(inflight) > maxinf) maxinf = int'(inflight);
`ifdef CORDIC_SCHED_STATS_EN
            for (int k = 0; k < N; k++) chk("grant_cnt", grant_cnt[k*16 +: 16], cnt[k]);
`endif
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && req_valid[(mptr + i) % N]) w = (mptr + i) % N;
            chk("req_ready", req_ready, w < 0 ? 0 : (1 << w));
            if (w >= 0) begin
                a = req_angle[w*AW +: AW];
                q.push_back('{id: w, x: cx(a), y: cy(a), due: cyc + L + 2});
                mptr = (w + 1) % N;
            end
`ifdef CORDIC_SCHED_STATS_EN
            for (int k = 0; k < N; k++)
                if (stats_clr) cnt[k] = 0;
                else if (k == w && cnt[k] < 65535) cnt[k]++;
`endif
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic [N*AW-1:0] ang);
        @(negedge clk);
        req_valid = v;
        req_angle = ang;
    endtask

    function automatic logic [N*AW-1:0] rnd_angles();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_cordic_angle"}, cordic_angle, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_x"}, rsp_x, 0);
        chk({tag, "_rsp_y"}, rsp_y, 0);
        chk({tag, "_inflight"}, inflight, 0);
    endtask

    logic [AW-1:0] sweep_a;
    int            seen;

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // single 45 degree request from requester 2
        drive(4'b0100, {32'h0, 32'h2000_0000, 32'h0, 32'h0});
        drive(4'b0000, '0);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            #2;
            if (rsp_valid) begin
                seen = 1;
                chk("diag45_id", rsp_id, 2);
                chk("diag45_xy", (rsp_x - rsp_y <= 2 && rsp_y - rsp_x <= 2) ? 1 : 0, 1);
            end
        end
        chk("diag45_seen", seen, 1);

        // fairness: everyone valid for 12 cycles
        maxinf = 0;
        repeat (12) drive(4'hF, rnd_angles());
        drive(4'h0, '0);
        repeat (L + 4) @(negedge clk);
        chk("peak_inflight", maxinf, L + 1);

        // sparse alternating requesters 1 and 3
        for (int i = 0; i < 20; i++) drive(i % 2 ? 4'b1000 : 4'b0010, rnd_angles());

        // angle sweep from requester 0
        for (int i = 0; i < 360; i++) begin
            sweep_a = AW'(((64'd1 << 32) * 64'(i)) / 64'd360);
            drive(4'b0001, {96'h0, sweep_a});
        end

        // random traffic
        repeat (300) drive(4'($urandom_range(0, 15)), rnd_angles());

        // reset with work in flight
        repeat (3) drive(4'hF, rnd_angles());
        repeat (4) drive(4'h0, '0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        drive(4'hF, rnd_angles());
        #2;
        chk("post_rst_grant", req_ready, 1);
        drive(4'h0, '0);
        repeat (L + 5) @(negedge clk);

`ifdef CORDIC_SCHED_STATS_EN
        repeat (70000) drive(4'b0010, rnd_angles());
        drive(4'h0, '0);
        #2;
        chk("sat_cnt1", grant_cnt[16 +: 16], 16'hFFFF);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #2;
        chk("stats_clr", grant_cnt, 0);
        repeat (L + 5) @(negedge clk);
`endif

        #2;
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
